// File: rtl/button_pkg.sv
// button_pkg: shared event codes, hold-counter width, arbiter state type and type-priority helper
package button_pkg;

   localparam logic [1:0] EVT_PRESS   = 2'b01;
   localparam logic [1:0] EVT_REPEAT  = 2'b10;
   localparam logic [1:0] EVT_RELEASE = 2'b11;

   localparam int HOLD_W = 9;

   typedef enum logic {S_IDLE, S_OFFER} arb_state_t;

   // Within one button a press always goes out before a repeat, and both before a release.
   function automatic logic [1:0] evt_pick(input logic press, input logic rep);
      return press ? EVT_PRESS : rep ? EVT_REPEAT : EVT_RELEASE;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after ptr
//   req     in   N            request vector
//   ptr     in   $clog2(N)    highest-priority index this round
//   gnt_idx out  $clog2(N)    index of the winner (0 when nothing requests)
//   gnt_any out  1            at least one request is set
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [$clog2(N)-1:0] gnt_idx,
   output logic                 gnt_any
);

   localparam int PW = $clog2(N);

   logic [N-1:0] rot;

   // Rotate so that bit 0 is the request at ptr, then the lowest set bit is the winner.
   always_comb begin
      rot     = N'({req, req} >> ptr);
      gnt_idx = '0;
      for (int k = N - 1; k >= 0; k--)
         if (rot[k]) gnt_idx = PW'((int'(ptr) + k) % N);
   end

   assign gnt_any = |req;

endmodule

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: turns debounced button levels into press/repeat/release events on one valid/ready channel
//   clk         in   1   system clock
//   rst_in      in   1   asynchronous active-low reset
//   button_lvl  in   N   debounced levels, 1 = pressed
//   evt_valid   out  1   event on offer
//   evt_ready   in   1   consumer takes the event when valid & ready at posedge
//   evt_id      out  4   index of the button behind the event
//   evt_type    out  2   01 press, 10 repeat, 11 release
//   overflow    out  1   sticky: an event was dropped
//   ovf_clr     in   1   synchronous clear of overflow (a same-cycle drop wins)
module button_event_arbiter
   import button_pkg::*;
#(
   parameter int NUM_BUTTONS   = 4,
   parameter int TICK_DIV_BITS = 15,
   parameter int REPEAT_DELAY  = 381,
   parameter int REPEAT_RATE   = 76
) (
   input  logic                   clk,
   input  logic                   rst_in,
   input  logic [NUM_BUTTONS-1:0] button_lvl,
   output logic                   evt_valid,
   input  logic                   evt_ready,
   output logic [3:0]             evt_id,
   output logic [1:0]             evt_type,
   output logic                   overflow,
   input  logic                   ovf_clr
);

   localparam int N  = NUM_BUTTONS;
   localparam int PW = $clog2(N);

   logic [TICK_DIV_BITS-1:0] presc;
   logic                     tick;
   logic                     armed;
   logic [N-1:0]             req, gnt_oh, ovf_hit;
   logic [N-1:0]             pend_press, pend_repeat, pend_release;
   logic [N-1:0]             clr_press, clr_repeat, clr_release;
   logic [PW-1:0]            ptr, gnt_idx;
   logic                     gnt_any, take, accept;
   arb_state_t               state, state_nxt;

   assign tick = &presc;

   // armed stays low for the first clock after reset so button_prev captures the
   // live levels without reporting a rise for buttons already held down.
   always_ff @(posedge clk or negedge rst_in)
      if (!rst_in) begin
         presc <= '0;
         armed <= 1'b0;
      end else begin
         presc <= presc + TICK_DIV_BITS'(1);
         armed <= 1'b1;
      end

   for (genvar g = 0; g < N; g++) begin : g_btn
      logic              prev, rise, fall, rep_hit;
      logic              p_press, p_repeat, p_release;
      logic [HOLD_W-1:0] hold_cnt;
      assign rise    = armed & button_lvl[g] & ~prev;
      assign fall    = armed & ~button_lvl[g] & prev;
      // A zero counter (button held through reset) never decrements, so it never repeats.
      assign rep_hit = tick & button_lvl[g] & ~rise & (hold_cnt == HOLD_W'(1));
      assign ovf_hit[g] = (rise & p_press & ~clr_press[g]) | (fall & p_release & ~clr_release[g]);
      assign pend_press[g]   = p_press;
      assign pend_repeat[g]  = p_repeat;
      assign pend_release[g] = p_release;
      always_ff @(posedge clk or negedge rst_in)
         if (!rst_in) begin
            prev      <= 1'b0;
            p_press   <= 1'b0;
            p_repeat  <= 1'b0;
            p_release <= 1'b0;
            hold_cnt  <= '0;
         end else begin
            prev      <= button_lvl[g];
            p_press   <= (p_press & ~clr_press[g]) | rise;
            p_repeat  <= ~fall & ((p_repeat & ~clr_repeat[g]) | rep_hit);
            p_release <= (p_release & ~clr_release[g]) | fall;
            if (rise)
               hold_cnt <= HOLD_W'(REPEAT_DELAY);
            else if (fall)
               hold_cnt <= '0;
            else if (tick && button_lvl[g] && hold_cnt != '0)
               hold_cnt <= rep_hit ? HOLD_W'(REPEAT_RATE) : hold_cnt - HOLD_W'(1);
         end
   end

   assign req = pend_press | pend_repeat | pend_release;

   rr_arbiter #(.N(N)) u_rr (
      .req     (req),
      .ptr     (ptr),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   always_ff @(posedge clk or negedge rst_in)
      if (!rst_in) state <= S_IDLE;
      else         state <= state_nxt;

   always_comb begin
      take      = 1'b0;
      accept    = 1'b0;
      state_nxt = state;
      if (state == S_IDLE) begin
         take      = gnt_any;
         state_nxt = gnt_any ? S_OFFER : S_IDLE;
      end else begin
         accept    = evt_ready;
         state_nxt = evt_ready ? S_IDLE : S_OFFER;
      end
   end

   // Only the highest-priority pending type of the winning button is consumed.
   assign gnt_oh      = take ? N'(1) << gnt_idx : '0;
   assign clr_press   = gnt_oh & pend_press;
   assign clr_repeat  = gnt_oh & ~pend_press & pend_repeat;
   assign clr_release = gnt_oh & ~pend_press & ~pend_repeat & pend_release;

   assign evt_valid = (state == S_OFFER);

   always_ff @(posedge clk or negedge rst_in)
      if (!rst_in) begin
         evt_id   <= '0;
         evt_type <= '0;
         ptr      <= '0;
         overflow <= 1'b0;
      end else begin
         if (take) begin
            evt_id   <= 4'(gnt_idx);
            evt_type <= evt_pick(pend_press[gnt_idx], pend_repeat[gnt_idx]);
         end
         if (accept)
            ptr <= (evt_id == 4'(N - 1)) ? '0 : PW'(evt_id + 4'd1);
         overflow <= (|ovf_hit) | (overflow & ~ovf_clr);
      end

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb_button_event_arbiter: directed checks of press/repeat/release generation, round-robin order, backpressure and reset
module tb_button_event_arbiter;
   import button_pkg::*;

   logic       clk = 1'b0;
   logic       rst_in = 1'b0;
   logic [3:0] button_lvl = '0;
   logic       evt_ready = 1'b0;
   logic       ovf_clr = 1'b0;
   logic       evt_valid;
   logic [3:0] evt_id;
   logic [1:0] evt_type;
   logic       overflow;

   int         checks = 0;
   int         errors = 0;
   logic [5:0] q[$];

   always #5 clk = ~clk;

   button_event_arbiter #(
      .NUM_BUTTONS   (4),
      .TICK_DIV_BITS (2),
      .REPEAT_DELAY  (3),
      .REPEAT_RATE   (2)
   ) dut (
      .clk        (clk),
      .rst_in     (rst_in),
      .button_lvl (button_lvl),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_id     (evt_id),
      .evt_type   (evt_type),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr)
   );

   // Handshake values are stable for the whole cycle, so sampling on the falling edge sees what the next rising edge accepts.
   always @(negedge clk)
      if (rst_in && evt_valid && evt_ready) q.push_back({evt_id, evt_type});

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tap(input int b);
      button_lvl[b] = 1'b1;
      step(4);
      button_lvl[b] = 1'b0;
      step(10);
   endtask

   initial begin
      int reps;
      int bad_id;
      int unstable;
      logic [6:0] snap;

      step(2);
      check("rst_valid", 32'(evt_valid), 0);
      check("rst_id", 32'(evt_id), 0);
      check("rst_type", 32'(evt_type), 0);
      check("rst_ovf", 32'(overflow), 0);
      rst_in = 1'b1;
      evt_ready = 1'b1;
      step(3);

      // Latency: edge register, then output latch.
      button_lvl[2] = 1'b1;
      step(1);
      check("t1_valid_c1", 32'(evt_valid), 0);
      step(1);
      check("t1_valid_c2", 32'(evt_valid), 1);
      check("t1_id", 32'(evt_id), 2);
      check("t1_type", 32'(evt_type), 32'(EVT_PRESS));
      step(2);
      button_lvl[2] = 1'b0;
      step(10);
      check("t1_count", 32'(q.size()), 2);
      check("t1_press", 32'(q[0]), 32'({4'd2, EVT_PRESS}));
      check("t1_release", 32'(q[1]), 32'({4'd2, EVT_RELEASE}));
      q.delete();

      // Hold button 0 for 80 clocks (~20 ticks): repeats on ticks 3,5,...,19.
      button_lvl[0] = 1'b1;
      step(80);
      button_lvl[0] = 1'b0;
      step(40);
      reps = 0;
      bad_id = 0;
      foreach (q[i]) begin
         if (q[i][1:0] == EVT_REPEAT) reps++;
         if (q[i][5:2] != 4'd0) bad_id++;
      end
      check("t2_count", 32'(q.size()), 11);
      check("t2_first", 32'(q[0]), 32'({4'd0, EVT_PRESS}));
      check("t2_repeats", 32'(reps), 9);
      check("t2_last", 32'(q[$]), 32'({4'd0, EVT_RELEASE}));
      check("t2_ids", 32'(bad_id), 0);
      q.delete();

      // Fairness: a tap of 3 moves the pointer to 0.
      tap(3);
      q.delete();
      button_lvl = 4'b1011;
      step(8);
      button_lvl = 4'b0000;
      step(20);
      check("t3a_first", 32'(q[0]), 32'({4'd0, EVT_PRESS}));
      check("t3a_second", 32'(q[1]), 32'({4'd1, EVT_PRESS}));
      check("t3a_third", 32'(q[2]), 32'({4'd3, EVT_PRESS}));
      q.delete();
      // A tap of 1 moves the pointer to 2.
      tap(1);
      q.delete();
      button_lvl = 4'b1011;
      step(8);
      button_lvl = 4'b0000;
      step(20);
      check("t3b_first", 32'(q[0]), 32'({4'd3, EVT_PRESS}));
      check("t3b_second", 32'(q[1]), 32'({4'd0, EVT_PRESS}));
      check("t3b_third", 32'(q[2]), 32'({4'd1, EVT_PRESS}));
      q.delete();

      // Backpressure.
      evt_ready = 1'b0;
      button_lvl[1] = 1'b1;
      step(3);
      snap = {evt_valid, evt_id, evt_type};
      check("t4_offer", 32'(snap), 32'({1'b1, 4'd1, EVT_PRESS}));
      unstable = 0;
      for (int i = 0; i < 50; i++) begin
         step(1);
         if ({evt_valid, evt_id, evt_type} !== snap) unstable++;
      end
      check("t4_stable", 32'(unstable), 0);
      check("t4_no_ovf_repeat", 32'(overflow), 0);
      button_lvl[1] = 1'b0;
      step(2);
      button_lvl[1] = 1'b1;
      step(2);
      button_lvl[1] = 1'b0;
      step(2);
      button_lvl[1] = 1'b1;
      step(2);
      check("t4_ovf_set", 32'(overflow), 1);
      check("t4_still_held", 32'({evt_valid, evt_id, evt_type}), 32'(snap));
      ovf_clr = 1'b1;
      step(1);
      ovf_clr = 1'b0;
      check("t4_ovf_clr", 32'(overflow), 0);
      button_lvl[1] = 1'b0;
      evt_ready = 1'b1;
      step(60);
      check("t4_drained", 32'(evt_valid), 0);
      q.delete();

      // Reset while an event is on offer.
      evt_ready = 1'b0;
      button_lvl[3] = 1'b1;
      step(3);
      check("t5_offer", 32'(evt_valid), 1);
      #2 rst_in = 1'b0;
      #1;
      check("t5_rst_valid", 32'(evt_valid), 0);
      check("t5_rst_id", 32'(evt_id), 0);
      check("t5_rst_type", 32'(evt_type), 0);
      check("t5_rst_ovf", 32'(overflow), 0);
      step(2);
      rst_in = 1'b1;
      evt_ready = 1'b1;
      q.delete();
      step(30);
      check("t5_no_press", 32'(q.size()), 0);
      button_lvl[3] = 1'b0;
      step(10);
      check("t5_count", 32'(q.size()), 1);
      check("t5_release", 32'(q[0]), 32'({4'd3, EVT_RELEASE}));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
